// File: rtl/smart_garage_door_ctrl.sv
// -----------------------------------------------------------------------------
// smart_garage_door_ctrl
//
// Purpose:
//   Controls a garage door motor from a single push-button command, two limit
//   switches and a beam-break sensor. Supports stop/reverse on command,
//   reversal on obstruction while closing, travel-time fault detection and an
//   optional auto-close timer when the door sits fully open.
//
// Parameters:
//   MAX_TRAVEL  cycles allowed in one direction before declaring a fault
//   AUTO_CLOSE  cycles fully open before closing automatically (0 = off)
//   CNT_W       width of the travel and auto-close counters
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-low reset
//   Activate  in   user command level; only rising edges act
//   Up_Max    in   open limit switch   (1 = fully open)
//   Dn_Max    in   closed limit switch (1 = fully closed)
//   Obstacle  in   beam-break sensor   (1 = obstruction)
//   UP_M      out  raise motor drive
//   DN_M      out  lower motor drive
//   Fault     out  fault indicator
// -----------------------------------------------------------------------------
module smart_garage_door_ctrl #(
    parameter int unsigned MAX_TRAVEL = 1000,
    parameter int unsigned AUTO_CLOSE = 5000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic Up_Max,
    input  logic Dn_Max,
    input  logic Obstacle,
    output logic UP_M,
    output logic DN_M,
    output logic Fault
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MV_UP   = 3'd1;
    localparam logic [2:0] S_MV_DN   = 3'd2;
    localparam logic [2:0] S_STOPPED = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [CNT_W-1:0] TRAVEL_LIMIT = CNT_W'(MAX_TRAVEL);
    // Auto-close fires on the cycle the counter would reach AUTO_CLOSE.
    // Only used when AUTO_CLOSE != 0, so the wrap for 0 is never seen.
    localparam logic [CNT_W-1:0] AUTO_LAST    = CNT_W'(AUTO_CLOSE - 1);
    localparam logic             AUTO_ON      = (AUTO_CLOSE != 0);

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] travel_q,   travel_d;
    logic [CNT_W-1:0] ac_q,       ac_d;
    logic             act_prev_q, act_prev_d;
    logic             armed_q,    armed_d;
    logic             last_up_q,  last_up_d;   // 1 = last motion was up

    logic act_rise;
    logic ac_en;
    logic moving_d;

    // Command edge detect. After reset, Activate must be seen low once
    // before any edge is accepted, so a button held through reset is inert.
    assign act_rise   = Activate & ~act_prev_q & armed_q;
    assign act_prev_d = Activate;
    assign armed_d    = armed_q | ~Activate;

    // Auto-close runs only while parked fully open with a clear beam.
    assign ac_en = AUTO_ON & Up_Max & ~Dn_Max & ~Obstacle;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        ac_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (Up_Max && Dn_Max) begin
                    state_d = S_FAULT;
                end else if (act_rise) begin
                    // Closing onto an obstruction from rest is refused.
                    if (Up_Max) begin
                        if (!Obstacle) state_d = S_MV_DN;
                    end else begin
                        state_d = S_MV_UP;
                    end
                end else if (ac_en) begin
                    if (ac_q == AUTO_LAST) state_d = S_MV_DN;
                    else                   ac_d    = ac_q + 1'b1;
                end
            end
            S_MV_UP: begin
                // Obstacle is deliberately ignored while opening.
                if (Up_Max)                        state_d = S_IDLE;
                else if (act_rise)                 state_d = S_STOPPED;
                else if (travel_q == TRAVEL_LIMIT) state_d = S_FAULT;
            end
            S_MV_DN: begin
                if (Dn_Max)                        state_d = S_IDLE;
                else if (Obstacle)                 state_d = S_MV_UP;
                else if (act_rise)                 state_d = S_STOPPED;
                else if (travel_q == TRAVEL_LIMIT) state_d = S_FAULT;
            end
            S_STOPPED: begin
                if (act_rise) begin
                    if (Obstacle || !last_up_q) state_d = S_MV_UP;
                    else                        state_d = S_MV_DN;
                end
            end
            S_FAULT: begin
                if (act_rise && (Up_Max ^ Dn_Max)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Travel counter restarts on every entry to a motion state (a reversal
    // changes state, so it restarts too) and saturates rather than wrapping.
    assign moving_d = (state_d == S_MV_UP) || (state_d == S_MV_DN);

    always_comb begin
        travel_d = '0;
        if (moving_d && (state_d == state_q)) begin
            travel_d = (&travel_q) ? travel_q : travel_q + 1'b1;
        end
    end

    always_comb begin
        last_up_d = last_up_q;
        if (state_q == S_MV_UP) last_up_d = 1'b1;
        if (state_q == S_MV_DN) last_up_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            travel_q   <= '0;
            ac_q       <= '0;
            act_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            last_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            travel_q   <= travel_d;
            ac_q       <= ac_d;
            act_prev_q <= act_prev_d;
            armed_q    <= armed_d;
            last_up_q  <= last_up_d;
        end
    end

    // Moore outputs: exact-match decode so unused encodings drive nothing.
    assign UP_M  = (state_q == S_MV_UP);
    assign DN_M  = (state_q == S_MV_DN);
    assign Fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_smart_garage_door_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smart_garage_door_ctrl
//
// Directed bench for smart_garage_door_ctrl with MAX_TRAVEL=8, AUTO_CLOSE=4.
// Each step drives inputs, queues the expected {UP_M,DN_M,Fault} for the
// following rising edge, and compares after that edge on the falling edge.
// -----------------------------------------------------------------------------
module tb_smart_garage_door_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic Activate, Up_Max, Dn_Max, Obstacle;
    logic UP_M, DN_M, Fault;

    typedef struct {
        string      tag;
        logic [2:0] exp;   // {UP_M, DN_M, Fault}
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [2:0] E_IDLE = 3'b000;
    localparam logic [2:0] E_UP   = 3'b100;
    localparam logic [2:0] E_DN   = 3'b010;
    localparam logic [2:0] E_F    = 3'b001;

    smart_garage_door_ctrl #(
        .MAX_TRAVEL (8),
        .AUTO_CLOSE (4),
        .CNT_W      (20)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Activate (Activate),
        .Up_Max   (Up_Max),
        .Dn_Max   (Dn_Max),
        .Obstacle (Obstacle),
        .UP_M     (UP_M),
        .DN_M     (DN_M),
        .Fault    (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic check_now(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {UP_M, DN_M, Fault};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: UP/DN/Fault observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic cyc(input string tag, input logic act, input logic up,
                       input logic dn, input logic obs, input logic [2:0] exp);
        exp_t e;
        Activate = act;
        Up_Max   = up;
        Dn_Max   = dn;
        Obstacle = obs;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, {UP_M, DN_M, Fault});
        end else begin
            e = sb.pop_front();
            check_now(e.tag, e.exp);
        end
    endtask

    initial begin
        RST      = 1'b0;
        Activate = 1'b1;
        Up_Max   = 1'b0;
        Dn_Max   = 1'b1;
        Obstacle = 1'b0;
        #12;
        check_now("reset_state", E_IDLE);
        @(negedge CLK);
        RST = 1'b1;

        // Button held through reset must not act until seen low once.
        cyc("held_after_rst0", 1, 0, 1, 0, E_IDLE);
        cyc("held_after_rst1", 1, 0, 1, 0, E_IDLE);
        cyc("act_low_arm",     0, 0, 1, 0, E_IDLE);
        cyc("first_rise_up",   1, 0, 1, 0, E_UP);

        // Open run, then the open limit returns to idle.
        for (int i = 0; i < 4; i++) cyc($sformatf("opening%0d", i), 0, 0, 0, 0, E_UP);
        cyc("up_limit_idle", 0, 1, 0, 0, E_IDLE);

        // Auto-close: obstacle on the third cycle restarts the count.
        cyc("ac_wait0",  0, 1, 0, 0, E_IDLE);
        cyc("ac_wait1",  0, 1, 0, 0, E_IDLE);
        cyc("ac_obs_clr",0, 1, 0, 1, E_IDLE);
        for (int i = 0; i < 3; i++) cyc($sformatf("ac_recount%0d", i), 0, 1, 0, 0, E_IDLE);
        cyc("auto_close_dn", 0, 1, 0, 0, E_DN);

        // Obstacle while closing reverses; the reversal restarts travel count,
        // and obstacle is ignored while opening.
        cyc("closing0",      0, 0, 0, 0, E_DN);
        cyc("closing1",      0, 0, 0, 0, E_DN);
        cyc("obs_reverse",   0, 0, 0, 1, E_UP);
        for (int i = 0; i < 8; i++)
            cyc($sformatf("rev_travel%0d", i), 0, 0, 0, (i < 2) ? 1'b1 : 1'b0, E_UP);
        cyc("up_travel_fault", 0, 0, 0, 0, E_F);

        // Fault exits only on an edge with exactly one limit set.
        cyc("fault_both_lim", 1, 1, 1, 0, E_F);
        cyc("fault_hold0",    0, 0, 0, 0, E_F);
        cyc("fault_no_lim",   1, 0, 0, 0, E_F);
        cyc("fault_hold1",    0, 0, 0, 0, E_F);
        cyc("fault_clear",    1, 0, 1, 0, E_IDLE);

        // Stop / resume, held button, and obstacle override in STOPPED.
        cyc("idle_closed",  0, 0, 1, 0, E_IDLE);
        cyc("open_cmd",     1, 0, 1, 0, E_UP);
        cyc("opening_a",    0, 0, 0, 0, E_UP);
        cyc("stop_cmd",     1, 0, 0, 0, E_IDLE);
        for (int i = 0; i < 20; i++) cyc($sformatf("held_stop%0d", i), 1, 0, 0, 0, E_IDLE);
        cyc("stop_release", 0, 0, 0, 0, E_IDLE);
        cyc("stop_obs_up",  1, 0, 0, 1, E_UP);
        cyc("opening_b",    0, 0, 0, 0, E_UP);
        cyc("stop_cmd2",    1, 0, 0, 0, E_IDLE);
        cyc("stop_rel2",    0, 0, 0, 0, E_IDLE);
        cyc("resume_dn",    1, 0, 0, 0, E_DN);

        // Closing without reaching the limit faults after MAX_TRAVEL.
        for (int i = 0; i < 8; i++) cyc($sformatf("dn_travel%0d", i), 0, 0, 0, 0, E_DN);
        cyc("dn_travel_fault", 0, 0, 0, 0, E_F);
        cyc("dn_fault_both",   1, 1, 1, 0, E_F);
        cyc("dn_fault_rel",    0, 0, 0, 0, E_F);
        cyc("dn_fault_clear",  1, 0, 1, 0, E_IDLE);

        // Both limits together in IDLE is a fault.
        cyc("both_limits",     0, 1, 1, 0, E_F);
        cyc("bl_hold",         0, 0, 1, 0, E_F);
        cyc("bl_clear",        1, 0, 1, 0, E_IDLE);

        // From open with obstacle the close command is refused.
        cyc("open_obs",        0, 1, 0, 1, E_IDLE);
        cyc("close_obs_block", 1, 1, 0, 1, E_IDLE);
        cyc("open_clear",      0, 1, 0, 0, E_IDLE);
        cyc("close_cmd",       1, 1, 0, 0, E_DN);
        cyc("closing_c",       0, 0, 0, 0, E_DN);
        cyc("stop_dn",         1, 0, 0, 0, E_IDLE);
        cyc("stop_dn_rel",     0, 0, 0, 0, E_IDLE);
        cyc("resume_up",       1, 0, 0, 0, E_UP);
        cyc("up_limit2",       0, 1, 0, 0, E_IDLE);
        cyc("open_wait",       0, 1, 0, 0, E_IDLE);
        cyc("close_cmd2",      1, 1, 0, 0, E_DN);
        cyc("closing_d",       0, 0, 0, 0, E_DN);

        // Asynchronous reset mid-close drops the motor before the next edge.
        #2 RST = 1'b0;
        #1 check_now("async_rst", E_IDLE);
        @(negedge CLK);
        check_now("rst_hold", E_IDLE);
        Activate = 1'b0;
        Dn_Max   = 1'b1;
        RST      = 1'b1;
        cyc("post_rst", 0, 0, 1, 0, E_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
